// File: rtl/gpu_rect_fill.sv
// -----------------------------------------------------------------------------
// gpu_rect_fill
//
// Rectangle fill engine for a cell framebuffer. Software programs X, Y, W, H
// and COLOR through a small register port and then issues a start command.
// The engine clips the rectangle against the framebuffer edges. It then
// streams one write beat per cell in row-major order over a valid/ready
// write port.
//
// Optional feature macro: GPU_FILL_IRQ_EN
//   When defined, an active-low completion interrupt (IRQ_N) is added. It
//   is low exactly while DONE is set.
//   When undefined, the port and its logic are absent.
//
// Parameters
//   FB_COLS    framebuffer width in cells (coordinates are 7-bit)
//   FB_ROWS    framebuffer height in cells
//
// Ports
//   CLK_SYS    sole clock, rising edge
//   RESET_N    asynchronous active-low reset
//   REG_WE     one-cycle register write strobe
//   REG_ADDR   0=X 1=Y 2=W 3=H 4=COLOR 5=CMD
//   REG_WDATA  register write data; CMD bit0=start, bit1=clear DONE/IRQ
//   STATUS     bit0 BUSY (CLIP or FILL), bit1 DONE
//   FB_ADDR    linear cell address y*FB_COLS+x
//   FB_DATA    cell colour {B,G,R}
//   FB_VALID   write beat offered
//   FB_READY   framebuffer accepts the beat this cycle
//   IRQ_N      completion interrupt, active low (GPU_FILL_IRQ_EN only)
// -----------------------------------------------------------------------------
module gpu_rect_fill #(
    parameter int FB_COLS = 80,
    parameter int FB_ROWS = 60
) (
    input  logic        CLK_SYS,
    input  logic        RESET_N,
    input  logic        REG_WE,
    input  logic [2:0]  REG_ADDR,
    input  logic [6:0]  REG_WDATA,
    output logic [1:0]  STATUS,
    output logic [12:0] FB_ADDR,
    output logic [2:0]  FB_DATA,
    output logic        FB_VALID,
    input  logic        FB_READY
`ifdef GPU_FILL_IRQ_EN
    ,
    output logic        IRQ_N
`endif
);

    localparam int ADDR_W = 13;

    localparam logic [7:0]        COLS_8 = 8'(FB_COLS);
    localparam logic [7:0]        ROWS_8 = 8'(FB_ROWS);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(FB_COLS);

    localparam logic [2:0] RA_X     = 3'd0;
    localparam logic [2:0] RA_Y     = 3'd1;
    localparam logic [2:0] RA_W     = 3'd2;
    localparam logic [2:0] RA_H     = 3'd3;
    localparam logic [2:0] RA_COLOR = 3'd4;
    localparam logic [2:0] RA_CMD   = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t state_q;

    // Programmable registers. Software may rewrite these at any time. A running
    // fill works only from its own snapshot.
    logic [6:0] reg_x, reg_y, reg_w, reg_h;
    logic [2:0] reg_color;

    // Snapshot taken at start. It is consumed by the CLIP cycle.
    logic [6:0] snap_x, snap_y, snap_w, snap_h;
    logic [2:0] snap_color;

    // Walk state during FILL.
    logic [ADDR_W-1:0] row_start;   // address of the first cell of the current row
    logic [7:0]        fill_w;      // clipped width, reloaded at each row start
    logic [7:0]        col_left;    // cells left in the current row, incl. current
    logic [7:0]        row_left;    // rows left, incl. current

    logic              busy_q;
    logic              done_q;
    logic              fb_valid_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [2:0]        fb_data_q;

    logic cmd_wr, cmd_start, cmd_clear;

    assign cmd_wr    = REG_WE && (REG_ADDR == RA_CMD);
    assign cmd_start = cmd_wr && REG_WDATA[0];
    assign cmd_clear = cmd_wr && REG_WDATA[1];

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its inputs from before the edge, whatever the order of
    // the statements.
    always_ff @(posedge CLK_SYS or negedge RESET_N) begin
        if (!RESET_N) begin
            reg_x     <= '0;
            reg_y     <= '0;
            reg_w     <= '0;
            reg_h     <= '0;
            reg_color <= '0;
        end else if (REG_WE) begin
            case (REG_ADDR)
                RA_X:     reg_x     <= REG_WDATA;
                RA_Y:     reg_y     <= REG_WDATA;
                RA_W:     reg_w     <= REG_WDATA;
                RA_H:     reg_h     <= REG_WDATA;
                RA_COLOR: reg_color <= REG_WDATA[2:0];
                default:  ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Clip arithmetic, evaluated from the snapshot during CLIP.
    // An origin outside the framebuffer yields zero. Otherwise the size is
    // limited to the room left to the right or bottom edge. This also keeps
    // every generated address inside the framebuffer.
    // -------------------------------------------------------------------------
    logic [7:0]        room_x, room_y;
    logic [7:0]        clip_w, clip_h;
    logic [ADDR_W-1:0] first_addr;

    // NOTE: every signal driven here gets a default value first. That way no
    // path through the block leaves one unassigned, which would infer a latch.
    always_comb begin
        room_x = '0;
        room_y = '0;
        clip_w = '0;
        clip_h = '0;
        if ({1'b0, snap_x} < COLS_8) begin
            room_x = COLS_8 - {1'b0, snap_x};
            clip_w = ({1'b0, snap_w} < room_x) ? {1'b0, snap_w} : room_x;
        end
        if ({1'b0, snap_y} < ROWS_8) begin
            room_y = ROWS_8 - {1'b0, snap_y};
            clip_h = ({1'b0, snap_h} < room_y) ? {1'b0, snap_h} : room_y;
        end
        // Constant-coefficient product. It is used once per fill. Later rows
        // are reached by adding FB_COLS to row_start.
        first_addr = ADDR_W'(snap_y) * COLS_A + ADDR_W'(snap_x);
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: every flop, including the snapshot and walk counters, is reset.
    // An aborted fill therefore leaves nothing behind that could resume after
    // reset is released.
    always_ff @(posedge CLK_SYS or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_w     <= '0;
            snap_h     <= '0;
            snap_color <= '0;
            row_start  <= '0;
            fill_w     <= '0;
            col_left   <= '0;
            row_left   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fb_valid_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            // A clear command may arrive in any state. A completion on the
            // same edge is assigned below and takes priority, so it is
            // never lost.
            if (cmd_clear) begin
                done_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_start) begin
                        snap_x     <= reg_x;
                        snap_y     <= reg_y;
                        snap_w     <= reg_w;
                        snap_h     <= reg_h;
                        snap_color <= reg_color;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CLIP;
                    end
                end

                CLIP: begin
                    if ((clip_w == 8'd0) || (clip_h == 8'd0)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        fb_valid_q <= 1'b1;
                        fb_addr_q  <= first_addr;
                        fb_data_q  <= snap_color;
                        row_start  <= first_addr;
                        fill_w     <= clip_w;
                        col_left   <= clip_w;
                        row_left   <= clip_h;
                        state_q    <= FILL;
                    end
                end

                FILL: begin
                    // A beat moves only when FB_READY is high. Otherwise
                    // address and data hold.
                    if (FB_READY) begin
                        if (col_left == 8'd1) begin
                            if (row_left == 8'd1) begin
                                fb_valid_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= IDLE;
                            end else begin
                                row_start <= row_start + COLS_A;
                                fb_addr_q <= row_start + COLS_A;
                                col_left  <= fill_w;
                                row_left  <= row_left - 8'd1;
                            end
                        end else begin
                            fb_addr_q <= fb_addr_q + 1'b1;
                            col_left  <= col_left - 8'd1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign STATUS   = {done_q, busy_q};
    assign FB_VALID = fb_valid_q;
    assign FB_ADDR  = fb_addr_q;
    assign FB_DATA  = fb_data_q;

`ifdef GPU_FILL_IRQ_EN
    // DONE is a flop that is set on completion and cleared by a clear or a
    // start command. Its inverse is therefore the interrupt line.
    assign IRQ_N = ~done_q;
`endif

endmodule

// File: tb/tb_gpu_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_gpu_rect_fill
//
// Self-checking bench for gpu_rect_fill (FB_COLS=80, FB_ROWS=60).
//
// The first part is a table of rectangles with hand-computed clip results.
// Each entry is run with FB_READY high. Every beat is checked against
// first + row*80 + col.
//
// Hand-written sequences then cover the following cases:
//   - ready back-pressure
//   - restart and colour writes during a fill
//   - reset during a fill
//   - the CMD clear bit
// -----------------------------------------------------------------------------
module tb_gpu_rect_fill;

    localparam int COLS = 80;

    logic        CLK_SYS;
    logic        RESET_N;
    logic        REG_WE;
    logic [2:0]  REG_ADDR;
    logic [6:0]  REG_WDATA;
    logic [1:0]  STATUS;
    logic [12:0] FB_ADDR;
    logic [2:0]  FB_DATA;
    logic        FB_VALID;
    logic        FB_READY;
`ifdef GPU_FILL_IRQ_EN
    logic        IRQ_N;
`endif

    gpu_rect_fill #(
        .FB_COLS (80),
        .FB_ROWS (60)
    ) dut (
        .CLK_SYS   (CLK_SYS),
        .RESET_N   (RESET_N),
        .REG_WE    (REG_WE),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .STATUS    (STATUS),
        .FB_ADDR   (FB_ADDR),
        .FB_DATA   (FB_DATA),
        .FB_VALID  (FB_VALID),
        .FB_READY  (FB_READY)
`ifdef GPU_FILL_IRQ_EN
        ,
        .IRQ_N     (IRQ_N)
`endif
    );

    initial CLK_SYS = 1'b0;
    always #5 CLK_SYS = ~CLK_SYS;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Check the interrupt pin when the option is built in (exp_done: DONE expected).
    task automatic check_irq(input string name, input logic exp_done);
`ifdef GPU_FILL_IRQ_EN
        check(name, 32'(IRQ_N), 32'(~exp_done));
`else
        if (exp_done === 1'bx) $display("%s", name);
`endif
    endtask

    // All stimulus is aligned to 1 time unit after a rising edge.
    task automatic step();
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [6:0] d);
        REG_WE    = 1'b1;
        REG_ADDR  = a;
        REG_WDATA = d;
        step();
        REG_WE    = 1'b0;
        REG_ADDR  = 3'd0;
        REG_WDATA = 7'd0;
    endtask

    task automatic set_rect(input logic [6:0] x, input logic [6:0] y,
                            input logic [6:0] w, input logic [6:0] h,
                            input logic [6:0] c);
        wr(3'd0, x);
        wr(3'd1, y);
        wr(3'd2, w);
        wr(3'd3, h);
        wr(3'd4, c);
    endtask

    // Beat monitor, sampled on the falling edge where everything is stable.
    logic        mon_en;
    logic [12:0] mon_addr[$];
    logic [2:0]  mon_data[$];

    always @(negedge CLK_SYS) begin
        if (mon_en && FB_VALID && FB_READY) begin
            mon_addr.push_back(FB_ADDR);
            mon_data.push_back(FB_DATA);
        end
    end

    typedef struct {
        logic [6:0] x;
        logic [6:0] y;
        logic [6:0] w;
        logic [6:0] h;
        logic [6:0] color;
        int         first;   // expected address of the first beat
        int         ew;      // expected clipped width
        int         eh;      // expected clipped height
    } vec_t;

    vec_t vecs[12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        RESET_N   = 1'b1;
        REG_WE    = 1'b0;
        REG_ADDR  = 3'd0;
        REG_WDATA = 7'd0;
        FB_READY  = 1'b1;
        mon_en    = 1'b0;

        //             x     y     w     h     col   first  ew  eh
        vecs[0]  = '{7'd2,  7'd3,  7'd4,  7'd2,  7'd5, 242,   4,  2};
        vecs[1]  = '{7'd78, 7'd59, 7'd10, 7'd10, 7'd3, 4798,  2,  1};
        vecs[2]  = '{7'd0,  7'd0,  7'd1,  7'd1,  7'd7, 0,     1,  1};
        vecs[3]  = '{7'd79, 7'd0,  7'd5,  7'd3,  7'd1, 79,    1,  3};
        vecs[4]  = '{7'd0,  7'd57, 7'd3,  7'd5,  7'd2, 4560,  3,  3};
        vecs[5]  = '{7'd0,  7'd0,  7'd0,  7'd5,  7'd4, 0,     0,  5};
        vecs[6]  = '{7'd80, 7'd0,  7'd4,  7'd2,  7'd6, 0,     0,  2};
        vecs[7]  = '{7'd5,  7'd60, 7'd4,  7'd2,  7'd6, 0,     4,  0};
        vecs[8]  = '{7'd127,7'd127,7'd127,7'd127,7'd7, 0,     0,  0};
        vecs[9]  = '{7'd0,  7'd0,  7'd127,7'd1,  7'd4, 0,     80, 1};
        vecs[10] = '{7'd10, 7'd20, 7'd2,  7'd0,  7'd5, 0,     2,  0};
        vecs[11] = '{7'd77, 7'd58, 7'd3,  7'd2,  7'd6, 4717,  3,  2};

        // ---------------- reset values ----------------
        #2 RESET_N = 1'b0;
        #1;
        check("reset STATUS",   32'(STATUS),   32'd0);
        check("reset FB_VALID", 32'(FB_VALID), 32'd0);
        check("reset FB_ADDR",  32'(FB_ADDR),  32'd0);
        check("reset FB_DATA",  32'(FB_DATA),  32'd0);
        check_irq("reset IRQ_N", 1'b0);
        step();
        step();
        RESET_N = 1'b1;
        step();

        // ---------------- table-driven fills ----------------
        for (int i = 0; i < 12; i++) begin
            set_rect(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color);
            wr(3'd5, 7'd1);
            // CLIP cycle: busy, no beat offered yet
            check($sformatf("v%0d clip STATUS", i),   32'(STATUS),   32'd1);
            check($sformatf("v%0d clip FB_VALID", i), 32'(FB_VALID), 32'd0);
            step();
            if (vecs[i].ew == 0 || vecs[i].eh == 0) begin
                check($sformatf("v%0d empty STATUS", i),   32'(STATUS),   32'd2);
                check($sformatf("v%0d empty FB_VALID", i), 32'(FB_VALID), 32'd0);
                check_irq($sformatf("v%0d empty IRQ_N", i), 1'b1);
            end else begin
                for (int r = 0; r < vecs[i].eh; r++) begin
                    for (int c = 0; c < vecs[i].ew; c++) begin
                        check($sformatf("v%0d r%0d c%0d FB_VALID", i, r, c), 32'(FB_VALID), 32'd1);
                        check($sformatf("v%0d r%0d c%0d FB_ADDR", i, r, c), 32'(FB_ADDR),
                              32'(vecs[i].first + r * COLS + c));
                        check($sformatf("v%0d r%0d c%0d FB_DATA", i, r, c), 32'(FB_DATA),
                              32'(vecs[i].color[2:0]));
                        check($sformatf("v%0d r%0d c%0d STATUS", i, r, c), 32'(STATUS), 32'd1);
                        step();
                    end
                end
                check($sformatf("v%0d end STATUS", i),   32'(STATUS),   32'd2);
                check($sformatf("v%0d end FB_VALID", i), 32'(FB_VALID), 32'd0);
                check_irq($sformatf("v%0d end IRQ_N", i), 1'b1);
            end
        end

        // ---------------- CMD clear ----------------
        wr(3'd5, 7'd2);
        check("clear STATUS", 32'(STATUS), 32'd0);
        check_irq("clear IRQ_N", 1'b0);

        // ---------------- back-pressure: READY 1,0,0,1,0,1 ----------------
        begin
            logic [5:0] pat;
            int         idx;
            pat = 6'b101001;   // bit k is READY in FILL cycle k
            idx = 0;
            set_rect(7'd10, 7'd1, 7'd3, 7'd1, 7'd6);
            wr(3'd5, 7'd1);
            step();
            for (int k = 0; k < 6; k++) begin
                check($sformatf("bp k%0d FB_VALID", k), 32'(FB_VALID), 32'd1);
                check($sformatf("bp k%0d FB_ADDR", k),  32'(FB_ADDR),  32'(90 + idx));
                check($sformatf("bp k%0d FB_DATA", k),  32'(FB_DATA),  32'd6);
                FB_READY = pat[k];
                if (pat[k]) idx++;
                step();
            end
            FB_READY = 1'b1;
            check("bp beats", 32'(idx), 32'd3);
            check("bp end STATUS",   32'(STATUS),   32'd2);
            check("bp end FB_VALID", 32'(FB_VALID), 32'd0);
        end

        // ---------------- restart and register writes during a fill ----------------
        mon_addr.delete();
        mon_data.delete();
        mon_en = 1'b1;
        set_rect(7'd0, 7'd0, 7'd5, 7'd5, 7'd1);
        wr(3'd5, 7'd1);
        step();
        wr(3'd4, 7'd6);    // colour change mid-fill
        wr(3'd5, 7'd1);    // restart mid-fill, must be ignored
        wr(3'd0, 7'd40);   // origin change mid-fill
        for (int k = 0; k < 100; k++) begin
            if (STATUS[1]) break;
            step();
        end
        check("mid DONE", 32'(STATUS), 32'd2);
        check("mid beats", 32'(mon_addr.size()), 32'd25);
        for (int b = 0; b < 25; b++) begin
            if (b < mon_addr.size()) begin
                check($sformatf("mid b%0d addr", b), 32'(mon_addr[b]), 32'((b / 5) * COLS + (b % 5)));
                check($sformatf("mid b%0d data", b), 32'(mon_data[b]), 32'd1);
            end
        end

        // ---------------- reset during a fill ----------------
        set_rect(7'd0, 7'd0, 7'd5, 7'd5, 7'd3);
        wr(3'd5, 7'd1);
        step();
        step();
        step();
        check("pre-reset FB_VALID", 32'(FB_VALID), 32'd1);
        RESET_N = 1'b0;
        mon_addr.delete();
        mon_data.delete();
        #1;
        check("abort FB_VALID", 32'(FB_VALID), 32'd0);
        check("abort STATUS",   32'(STATUS),   32'd0);
        check("abort FB_ADDR",  32'(FB_ADDR),  32'd0);
        check("abort FB_DATA",  32'(FB_DATA),  32'd0);
        check_irq("abort IRQ_N", 1'b0);
        step();
        step();
        RESET_N = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("post-reset beats",    32'(mon_addr.size()), 32'd0);
        check("post-reset FB_VALID", 32'(FB_VALID), 32'd0);
        check("post-reset STATUS",   32'(STATUS),   32'd0);

        // Registers were cleared by reset, so W=H=0 gives an empty fill.
        wr(3'd5, 7'd1);
        check("zero-reg clip STATUS", 32'(STATUS), 32'd1);
        step();
        check("zero-reg STATUS",   32'(STATUS),   32'd2);
        check("zero-reg FB_VALID", 32'(FB_VALID), 32'd0);
        check("zero-reg beats",    32'(mon_addr.size()), 32'd0);
        check_irq("zero-reg IRQ_N", 1'b1);
        wr(3'd5, 7'd2);
        check("final clear STATUS", 32'(STATUS), 32'd0);
        check_irq("final clear IRQ_N", 1'b0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
